c_align_buffer: RTL and testbench
=================================

// Module: c_align_buffer
// PURPOSE
//  Parametrised fetch-side parcel buffer for the RV32 C-extension front end; next-generation successor to the misalign stage.
//  Accepts aligned fetch words of FETCH_W bits, splits them into 16-bit parcels, and emits one raw instruction per handshake.
//  Each emitted instruction is 16-bit (compressed) or 32-bit, including 32-bit instructions that straddle fetch words.
//  Sits between the I-fetch port and c_decode. Replaces PC stalling with valid/ready back-pressure and handles branch flush.
// PARAMETERS
//  FETCH_W   32          fetch word width in bits; 32 or 64
//  DEPTH     8           buffer depth in 16-bit parcels; power of 2, >= 2*FETCH_W/16
//  RESET_PC  32'h0       head PC loaded on reset
// PORTS
//  clk           in   1        clock; all state updates on rising edge
//  reset_i       in   1        synchronous active-high reset
//  fetch_valid_i in   1        fetch word present
//  fetch_ready_o out  1        buffer can accept a whole fetch word this cycle
//  fetch_pc_i    in   32       address of fetch word, FETCH_W/8-aligned
//  fetch_data_i  in   FETCH_W  fetch word; parcel 0 in bits [15:0]
//  br_taken_i    in   1        redirect: flush buffer
//  br_target_i   in   32       redirect target, 2-byte aligned
//  instr_valid_o out  1        complete instruction at head
//  instr_ready_i in   1        consumer takes instruction
//  instr_o       out  32       raw instruction; compressed -> {16'h0, parcel}
//  instr_pc_o    out  32       PC of instr_o
//  instr_c_o     out  1        1 = 16-bit instruction (parcel[1:0] != 2'b11)
// BEHAVIOUR
//  - State: parcel ring (DEPTH x 16), rd_ptr, wr_ptr (log2 DEPTH, wrap mod DEPTH), count (0..DEPTH), head_pc, skip (parcels to drop).
//  - Reset: count=0, pointers=0, head_pc=RESET_PC, skip=0. While reset_i=1: fetch_ready_o=0, instr_valid_o=0.
//  - After reset: fetch_ready_o=1, instr_valid_o=0, instr_o=0, instr_pc_o=RESET_PC, instr_c_o=0 while empty.
//  - fetch_ready_o = (DEPTH-count >= FETCH_W/16); uses pre-pop count; no combinational path from instr_ready_i.
//  - Push (fetch_valid_i & fetch_ready_o & !br_taken_i): write parcels skip..FETCH_W/16-1 in order; skip then clears to 0.
//  - Head decode: c = (head[1:0] != 2'b11); need = c ? 1 : 2.
//  - instr_valid_o = (count >= need), combinational from state. Zero latency when the head parcel is already resident.
//  - Straddle: 32-bit instruction with one resident parcel -> valid=0 until the next push; valid in the cycle after that push.
//  - Pop (instr_valid_o & instr_ready_i): rd_ptr += need; head_pc += 2*need.
//  - Push and pop in the same cycle: count_next = count + pushed - need; full/empty decided on pre-update count.
//  - instr_o and instr_pc_o are stable while valid=1 and ready=0.
//  - Flush (br_taken_i=1): highest priority, regardless of handshakes this cycle.
//    * count=0, rd_ptr=wr_ptr=0, head_pc=br_target_i.
//    * skip=br_target_i[log2(FETCH_W/8)-1:1].
//    * Any same-cycle push or pop is discarded; the consumer must ignore the instruction in that cycle.
//  - Fetch words are taken in order; fetch_pc_i is not checked against head_pc (fetch unit guarantees sequence).
//  - Reset asserted mid-operation overrides flush and all handshakes; the buffer contents are lost.
//  - Parcel 16'h0000 is passed through as compressed (instr_c_o=1); the illegal decision is left to c_decode.
// STRUCTURE
//  - c_pkg holds:
//    * typedef logic [15:0] parcel_t
//    * localparam PARCELS_PER_FETCH = FETCH_W/16
//    * function is_compressed(parcel_t)
//  - Sub-module c_parcel_fifo: ring storage, pointers, count.
//    * Multi-parcel write with skip; read of 2 consecutive parcels (wrap-aware); pop by 1 or 2.
//  - Top-level keeps head_pc, skip, flush priority and head decode.
// TESTING
//  1 FETCH_W=32, words 32'h0001_4501, 32'h0000_0013 at PC 0,4
//    -> 16'h4501 @0 (c=1); 16'h0001 @2 (c=1); 32'h13 @4 (c=0).
//  2 Straddle: word 32'h0513_4505 @0 then 32'h0000_0000 @4
//    -> 16'h4505 @0; then valid=0 until second push; then 32'h0000_0513 @2 (c=0); then 16'h0000 @6.
//  3 Full: instr_ready_i=0, push 4 words into DEPTH=8
//    -> fetch_ready_o=0 after 4th push; one 32-bit pop -> ready=1 next cycle, not same cycle.
//  4 br_taken_i=1, br_target_i=32'h102 with simultaneous push and pop
//    -> both discarded; next word @0x100 drops parcel 0; first instr_pc_o=32'h102.
//  5 FETCH_W=64, DEPTH=16, mixed 16/32-bit stream, random ready
//    -> emitted instructions match reference-model order and PCs; no loss across pointer wrap.
//  6 reset_i pulsed with count=5 -> next cycle count=0, instr_valid_o=0, instr_pc_o=RESET_PC.

Source files
------------

// File: rtl/c_pkg.sv
// rtl/c_pkg.sv - shared parcel type, fetch geometry and compressed-instruction decode
package c_pkg;

    typedef logic [15:0] parcel_t;

    localparam int FETCH_W_DEFAULT   = 32;
    localparam int PARCELS_PER_FETCH = FETCH_W_DEFAULT / 16;

    // RV32C: anything whose low two bits are not 2'b11 is a 16-bit instruction
    function automatic logic is_compressed(input parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/c_parcel_fifo.sv
// rtl/c_parcel_fifo.sv - parcel ring with multi-parcel write (leading skip) and 1/2-parcel pop
module c_parcel_fifo
    import c_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PPF   = PARCELS_PER_FETCH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int SW   = (PPF > 1) ? $clog2(PPF) : 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [SW-1:0]     wr_skip,
    input  logic [PPF*16-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_two,
    output logic [CW-1:0]     count,
    output parcel_t           rd_data0,
    output parcel_t           rd_data1
);

    parcel_t       mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] wr_num;
    logic [CW-1:0] rd_num;

    always_comb begin
        wr_num = '0;
        rd_num = '0;
        if (wr_en) wr_num = CW'(PPF) - CW'(wr_skip);
        if (rd_en) rd_num = rd_two ? CW'(2) : CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(rd_num);
            wr_ptr <= wr_ptr + PW'(wr_num);
            count  <= count + wr_num - rd_num;
        end
    end

    // Parcels below the skip index are dropped; the rest pack down from wr_ptr
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < PPF; i++) begin
                if (i >= int'(wr_skip))
                    mem[wr_ptr + PW'(i) - PW'(wr_skip)] <= wr_data[i*16 +: 16];
            end
        end
    end

    assign rd_data0 = mem[rd_ptr];
    assign rd_data1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/c_align_buffer.sv
// rtl/c_align_buffer.sv - fetch-word to instruction aligner with back-pressure and branch flush
module c_align_buffer
    import c_pkg::*;
#(
    parameter int          FETCH_W  = 32,
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [31:0]        fetch_pc_i,
    input  logic [FETCH_W-1:0] fetch_data_i,
    input  logic               br_taken_i,
    input  logic [31:0]        br_target_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic [31:0]        instr_pc_o,
    output logic               instr_c_o
);

    localparam int PPF = FETCH_W / 16;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int SW  = (PPF > 1) ? $clog2(PPF) : 1;
    localparam int BW  = $clog2(FETCH_W / 8);

    logic [31:0]   head_pc;
    logic [SW-1:0] skip;
    logic [CW-1:0] count;
    parcel_t       p0;
    parcel_t       p1;
    logic          head_c;
    logic          push;
    logic          pop;
    logic          clear;
    logic          unused_fetch_pc;

    // Fetch order is guaranteed upstream, so the word address carries no information here
    assign unused_fetch_pc = ^fetch_pc_i;

    assign head_c        = is_compressed(p0);
    assign fetch_ready_o = !reset_i && ((CW'(DEPTH) - count) >= CW'(PPF));
    assign instr_valid_o = !reset_i && (count >= (head_c ? CW'(1) : CW'(2)));
    assign push          = fetch_valid_i && fetch_ready_o && !br_taken_i;
    assign pop           = instr_valid_o && instr_ready_i && !br_taken_i;
    assign clear         = reset_i || br_taken_i;

    assign instr_o    = !instr_valid_o ? 32'h0 : (head_c ? {16'h0, p0} : {p1, p0});
    assign instr_c_o  = instr_valid_o && head_c;
    assign instr_pc_o = head_pc;

    c_parcel_fifo #(
        .DEPTH (DEPTH),
        .PPF   (PPF)
    ) u_fifo (
        .clk      (clk),
        .clear    (clear),
        .wr_en    (push),
        .wr_skip  (skip),
        .wr_data  (fetch_data_i),
        .rd_en    (pop),
        .rd_two   (!head_c),
        .count    (count),
        .rd_data0 (p0),
        .rd_data1 (p1)
    );

    // A redirect into the middle of a fetch word drops the parcels ahead of the target
    always_ff @(posedge clk) begin
        if (reset_i) begin
            head_pc <= RESET_PC;
            skip    <= '0;
        end else if (br_taken_i) begin
            head_pc <= br_target_i;
            skip    <= br_target_i[BW-1:1];
        end else begin
            if (push) skip <= '0;
            if (pop)  head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
        end
    end

endmodule

// File: tb/tb_c_align_buffer.sv
// tb/tb_c_align_buffer.sv - directed vector table (32-bit fetch) plus 64-bit mixed-stream run
module tb_c_align_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_fv, a_fready, a_br, a_valid, a_rdy, a_c;
    logic [31:0] a_pc, a_data, a_tgt, a_instr, a_ipc;

    logic        b_rst, b_fv, b_fready, b_br, b_valid, b_rdy, b_c;
    logic [31:0] b_pc, b_tgt, b_instr, b_ipc;
    logic [63:0] b_data;

    c_align_buffer #(.FETCH_W(32), .DEPTH(8), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset_i(a_rst), .fetch_valid_i(a_fv), .fetch_ready_o(a_fready),
        .fetch_pc_i(a_pc), .fetch_data_i(a_data), .br_taken_i(a_br), .br_target_i(a_tgt),
        .instr_valid_o(a_valid), .instr_ready_i(a_rdy), .instr_o(a_instr),
        .instr_pc_o(a_ipc), .instr_c_o(a_c)
    );

    c_align_buffer #(.FETCH_W(64), .DEPTH(16), .RESET_PC(32'h0)) dut_b (
        .clk(clk), .reset_i(b_rst), .fetch_valid_i(b_fv), .fetch_ready_o(b_fready),
        .fetch_pc_i(b_pc), .fetch_data_i(b_data), .br_taken_i(b_br), .br_target_i(b_tgt),
        .instr_valid_o(b_valid), .instr_ready_i(b_rdy), .instr_o(b_instr),
        .instr_pc_o(b_ipc), .instr_c_o(b_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, fv;
        logic [31:0] word, pc;
        logic        rdy, br;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
        logic        e_c, e_fready;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic fv, input logic [31:0] word,
                               input logic [31:0] pc, input logic rdy, input logic br,
                               input logic [31:0] tgt, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep, input logic ec, input logic ef);
        vec_t r;
        r.rst = rst; r.fv = fv; r.word = word; r.pc = pc; r.rdy = rdy; r.br = br; r.tgt = tgt;
        r.e_valid = ev; r.e_instr = ei; r.e_pc = ep; r.e_c = ec; r.e_fready = ef;
        return r;
    endfunction

    typedef struct {
        logic [31:0] instr, pc;
        logic        c;
    } exp_t;

    vec_t        vecs[$];
    exp_t        expq[$];
    logic [15:0] par[$];

    initial begin
        // Inputs are applied at the falling edge; outputs sampled 1 time unit later
        // reflect the state latched at the previous rising edge.
        // Basic stream: two compressed then one 32-bit
        vecs.push_back(v(0,1,32'h0001_4501,32'h0,1,0,0, 0,32'h0,32'h0,0,1));
        vecs.push_back(v(0,1,32'h0000_0013,32'h4,1,0,0, 1,32'h4501,32'h0,1,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         1,32'h0001,32'h2,1,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         1,32'h13,32'h4,0,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         0,32'h0,32'h8,0,1));
        // Straddling 32-bit instruction
        vecs.push_back(v(1,0,32'h0,32'h0,0,0,0,         0,32'h0,32'h8,0,0));
        vecs.push_back(v(0,1,32'h0513_4505,32'h0,1,0,0, 0,32'h0,32'h0,0,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         1,32'h4505,32'h0,1,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         0,32'h0,32'h2,0,1));
        vecs.push_back(v(0,1,32'h0,32'h4,1,0,0,         0,32'h0,32'h2,0,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         1,32'h0000_0513,32'h2,0,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         1,32'h0,32'h6,1,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         0,32'h0,32'h8,0,1));
        // Fill to DEPTH with consumer stalled; ready returns only after the pop lands
        vecs.push_back(v(1,0,32'h0,32'h0,0,0,0,         0,32'h0,32'h8,0,0));
        vecs.push_back(v(0,1,32'h0000_0013,32'h0,0,0,0, 0,32'h0,32'h0,0,1));
        vecs.push_back(v(0,1,32'h1111_1111,32'h4,0,0,0, 1,32'h13,32'h0,0,1));
        vecs.push_back(v(0,1,32'h1111_1111,32'h8,0,0,0, 1,32'h13,32'h0,0,1));
        vecs.push_back(v(0,1,32'h1111_1111,32'hc,0,0,0, 1,32'h13,32'h0,0,1));
        vecs.push_back(v(0,1,32'h2222_2222,32'h10,1,0,0,1,32'h13,32'h0,0,0));
        vecs.push_back(v(0,0,32'h0,32'h0,0,0,0,         1,32'h1111,32'h4,1,1));
        // Flush to 0x102 with simultaneous push and pop
        vecs.push_back(v(0,1,32'h3333_3333,32'h10,1,1,32'h102, 1,32'h1111,32'h4,1,1));
        vecs.push_back(v(0,1,32'h0013_4599,32'h100,1,0,0, 0,32'h0,32'h102,0,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         0,32'h0,32'h102,0,1));
        vecs.push_back(v(0,1,32'h5555_0000,32'h104,1,0,0, 0,32'h0,32'h102,0,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         1,32'h13,32'h102,0,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         1,32'h5555,32'h106,1,1));
        vecs.push_back(v(0,0,32'h0,32'h0,1,0,0,         0,32'h0,32'h108,0,1));
        // Build count=5 then reset mid-operation
        vecs.push_back(v(0,1,32'h1111_1111,32'h108,0,0,0, 0,32'h0,32'h108,0,1));
        vecs.push_back(v(0,1,32'h1111_1111,32'h10c,0,0,0, 1,32'h1111,32'h108,1,1));
        vecs.push_back(v(0,1,32'h1111_1111,32'h110,1,0,0, 1,32'h1111,32'h108,1,1));
        vecs.push_back(v(0,0,32'h0,32'h0,0,0,0,         1,32'h1111,32'h10a,1,1));
        vecs.push_back(v(1,1,32'h1111_1111,32'h114,1,0,0, 0,32'h0,32'h10a,0,0));
        vecs.push_back(v(0,0,32'h0,32'h0,0,0,0,         0,32'h0,32'h0,0,1));

        a_rst = 1; a_fv = 0; a_pc = 0; a_data = 0; a_br = 0; a_tgt = 0; a_rdy = 0;
        b_rst = 1; b_fv = 0; b_pc = 0; b_data = 0; b_br = 0; b_tgt = 0; b_rdy = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset fetch_ready", 32'(a_fready), 32'h0);
        chk("reset instr_valid", 32'(a_valid), 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            a_rst = vecs[i].rst; a_fv = vecs[i].fv; a_data = vecs[i].word; a_pc = vecs[i].pc;
            a_rdy = vecs[i].rdy; a_br = vecs[i].br; a_tgt = vecs[i].tgt;
            b_rst = 0;
            #1;
            chk($sformatf("v%0d instr_valid", i), 32'(a_valid),  32'(vecs[i].e_valid));
            chk($sformatf("v%0d instr", i),       a_instr,        vecs[i].e_instr);
            chk($sformatf("v%0d instr_pc", i),    a_ipc,          vecs[i].e_pc);
            chk($sformatf("v%0d instr_c", i),     32'(a_c),       32'(vecs[i].e_c));
            chk($sformatf("v%0d fetch_ready", i), 32'(a_fready),  32'(vecs[i].e_fready));
        end

        // 64-bit fetch, mixed stream, random back-pressure, wraps the 16-parcel ring repeatedly
        begin
            int          pcm = 0;
            logic [15:0] p, lo, hi;
            while (par.size() < 160) begin
                if (par.size() == 159 || $urandom_range(1, 0) == 0) begin
                    p = 16'($urandom);
                    if (p[1:0] == 2'b11) p[1:0] = 2'b01;
                    par.push_back(p);
                    expq.push_back('{{16'h0, p}, 32'(pcm), 1'b1});
                    pcm += 2;
                end else begin
                    lo = 16'($urandom); lo[1:0] = 2'b11;
                    hi = 16'($urandom);
                    par.push_back(lo);
                    par.push_back(hi);
                    expq.push_back('{{hi, lo}, 32'(pcm), 1'b0});
                    pcm += 4;
                end
            end
        end
        begin
            int w = 0;
            int k = 0;
            int cyc = 0;
            while (k < expq.size() && cyc < 4000) begin
                @(negedge clk);
                b_fv = (w < 40) && ($urandom_range(3, 0) != 0);
                if (w < 40) b_data = {par[4*w+3], par[4*w+2], par[4*w+1], par[4*w]};
                b_pc  = 32'(w * 8);
                b_rdy = 1'($urandom_range(1, 0));
                #1;
                if (b_fv && b_fready) w++;
                if (b_valid && b_rdy) begin
                    chk($sformatf("w64 #%0d instr", k),   b_instr,   expq[k].instr);
                    chk($sformatf("w64 #%0d pc", k),      b_ipc,     expq[k].pc);
                    chk($sformatf("w64 #%0d instr_c", k), 32'(b_c),  32'(expq[k].c));
                    k++;
                end
                cyc++;
            end
            @(negedge clk);
            b_fv = 0; b_rdy = 0;
            chk("w64 all instructions emitted", 32'(k), 32'(expq.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
